// File: rtl/dmem_ctx_arbiter.sv
// dmem_ctx_arbiter: shares the single-port data memory between single-word MEM-stage
// accesses and two-cycle context push/pop bursts from the interrupt/call unit.
module dmem_ctx_arbiter #(
    parameter int AW = 11,
    parameter int DW = 16
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            pipe_req,
    input  logic            pipe_we,
    input  logic [AW-1:0]   pipe_addr,
    input  logic [DW-1:0]   pipe_wdata,
    output logic            pipe_gnt,
    output logic            pipe_stall,
    output logic [DW-1:0]   pipe_rdata,
    input  logic            ctx_req,
    input  logic            ctx_op,
    input  logic [AW-1:0]   ctx_sp,
    input  logic [2*DW-1:0] ctx_wdata,
    output logic [2*DW-1:0] ctx_rdata,
    output logic [AW-1:0]   ctx_sp_out,
    output logic            ctx_done,
    output logic            mem_we,
    output logic            mem_re,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata
);

    typedef enum logic [1:0] {IDLE, XFER1, XFER2, DONE} state_t;

    state_t          state, state_nxt;
    logic            op_q;
    logic [AW-1:0]   sp_q;
    logic [2*DW-1:0] wdata_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= IDLE;
            op_q       <= 1'b0;
            sp_q       <= '0;
            wdata_q    <= '0;
            ctx_rdata  <= '0;
            ctx_sp_out <= '0;
            ctx_done   <= 1'b0;
        end else begin
            state    <= state_nxt;
            ctx_done <= (state == XFER2);
            if (state == IDLE && ctx_req) begin
                op_q    <= ctx_op;
                sp_q    <= ctx_sp;
                wdata_q <= ctx_wdata;
            end
            if (state == XFER1 && op_q)
                ctx_rdata[DW-1:0] <= mem_rdata;
            if (state == XFER2) begin
                if (op_q)
                    ctx_rdata[2*DW-1:DW] <= mem_rdata;
                ctx_sp_out <= op_q ? sp_q + AW'(2) : sp_q - AW'(2);
            end
        end
    end

    // Push stores hi at sp then lo at sp-1; pop reads lo at sp+1 then hi at sp+2,
    // so a pop directly after a push returns the same {hi, lo} word.
    always_comb begin
        state_nxt = state;
        pipe_gnt  = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!Rst) begin
            case (state)
                IDLE: begin
                    pipe_gnt = pipe_req;
                    if (ctx_req)
                        state_nxt = XFER1;
                end
                XFER1: begin
                    state_nxt = XFER2;
                    mem_we    = ~op_q;
                    mem_re    = op_q;
                    mem_addr  = op_q ? sp_q + AW'(1) : sp_q;
                    mem_wdata = op_q ? '0 : wdata_q[2*DW-1:DW];
                end
                XFER2: begin
                    state_nxt = DONE;
                    mem_we    = ~op_q;
                    mem_re    = op_q;
                    mem_addr  = op_q ? sp_q + AW'(2) : sp_q - AW'(1);
                    mem_wdata = op_q ? '0 : wdata_q[DW-1:0];
                end
                DONE: begin
                    pipe_gnt  = pipe_req;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
            if (pipe_gnt) begin
                mem_we    = pipe_we;
                mem_re    = ~pipe_we;
                mem_addr  = pipe_addr;
                mem_wdata = pipe_wdata;
            end
        end
    end

    assign pipe_stall = pipe_req & ~pipe_gnt;
    assign pipe_rdata = mem_rdata;

endmodule

// File: tb/tb_dmem_ctx_arbiter.sv
// Scoreboard bench for dmem_ctx_arbiter: a cycle reference model queues the expected
// bus/handshake view of every cycle; a monitor pops and compares each cycle.
module tb_dmem_ctx_arbiter;

    localparam int AW = 11;
    localparam int DW = 16;

    logic            Clk = 1'b0;
    logic            Rst = 1'b1;
    logic            pipe_req = 1'b0, pipe_we = 1'b0;
    logic [AW-1:0]   pipe_addr = '0;
    logic [DW-1:0]   pipe_wdata = '0;
    logic            pipe_gnt, pipe_stall;
    logic [DW-1:0]   pipe_rdata;
    logic            ctx_req = 1'b0, ctx_op = 1'b0;
    logic [AW-1:0]   ctx_sp = '0;
    logic [2*DW-1:0] ctx_wdata = '0;
    logic [2*DW-1:0] ctx_rdata;
    logic [AW-1:0]   ctx_sp_out;
    logic            ctx_done;
    logic            mem_we, mem_re;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;

    dmem_ctx_arbiter #(.AW(AW), .DW(DW)) dut (
        .Clk(Clk), .Rst(Rst),
        .pipe_req(pipe_req), .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
        .pipe_gnt(pipe_gnt), .pipe_stall(pipe_stall), .pipe_rdata(pipe_rdata),
        .ctx_req(ctx_req), .ctx_op(ctx_op), .ctx_sp(ctx_sp), .ctx_wdata(ctx_wdata),
        .ctx_rdata(ctx_rdata), .ctx_sp_out(ctx_sp_out), .ctx_done(ctx_done),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 Clk = ~Clk;

    function automatic logic [DW-1:0] init_val(int i);
        return DW'(i * 40503) ^ 16'h5a5a;
    endfunction

    // Environment memory: the real 2K x 16 array the arbiter drives.
    logic [DW-1:0] mem [0:2047];
    assign mem_rdata = mem[mem_addr];
    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = init_val(i);
        forever begin
            @(posedge Clk);
            if (mem_we) mem[mem_addr] <= mem_wdata;
        end
    end

    typedef struct packed {
        logic            gnt, stall, we, re, done, chk_rd;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   wdata, rdata;
        logic [2*DW-1:0] crd;
        logic [AW-1:0]   csp;
    } cyc_t;

    cyc_t cq[$];
    int   passed = 0, total = 0, mcyc = 0;

    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s cycle %0d: got %h expected %h", n, mcyc, act, exp);
    endfunction

    // Reference model: memory contents plus "cycles since burst acceptance" (0 = free).
    logic [DW-1:0]   ref_mem [0:2047];
    int              k = 0;
    logic            m_op;
    logic [AW-1:0]   m_sp;
    logic [2*DW-1:0] m_wd;
    logic [2*DW-1:0] m_rd = '0;
    logic [AW-1:0]   m_spo = '0;

    task automatic model_cycle();
        cyc_t e;
        logic [AW-1:0] a;
        e = '0;
        e.done = (k == 3);
        e.crd  = m_rd;
        e.csp  = m_spo;
        if (Rst) begin
            e.stall = pipe_req;
            k = 0; m_rd = '0; m_spo = '0;
        end else if (k == 0 || k == 3) begin
            if (pipe_req) begin
                e.gnt = 1'b1; e.we = pipe_we; e.re = ~pipe_we;
                e.addr = pipe_addr; e.wdata = pipe_wdata;
                if (pipe_we) ref_mem[pipe_addr] = pipe_wdata;
                else begin e.chk_rd = 1'b1; e.rdata = ref_mem[pipe_addr]; end
            end
            if (k == 0 && ctx_req) begin
                k = 1; m_op = ctx_op; m_sp = ctx_sp; m_wd = ctx_wdata;
            end else k = 0;
        end else begin
            e.stall = pipe_req;
            if (m_op) begin
                a = (k == 1) ? m_sp + 11'd1 : m_sp + 11'd2;
                e.re = 1'b1;
                if (k == 1) m_rd[15:0] = ref_mem[a];
                else m_rd[31:16] = ref_mem[a];
            end else begin
                a = (k == 1) ? m_sp : m_sp - 11'd1;
                e.we = 1'b1;
                e.wdata = (k == 1) ? m_wd[31:16] : m_wd[15:0];
                ref_mem[a] = e.wdata;
            end
            e.addr = a;
            if (k == 2) m_spo = m_op ? m_sp + 11'd2 : m_sp - 11'd2;
            k = k + 1;
        end
        cq.push_back(e);
    endtask

    task automatic step(input logic r, input logic preq, input logic pwe,
                        input logic [AW-1:0] pa, input logic [DW-1:0] pwd,
                        input logic creq, input logic cop, input logic [AW-1:0] sp,
                        input logic [2*DW-1:0] cwd);
        @(negedge Clk);
        Rst = r; pipe_req = preq; pipe_we = pwe; pipe_addr = pa; pipe_wdata = pwd;
        ctx_req = creq; ctx_op = cop; ctx_sp = sp; ctx_wdata = cwd;
        model_cycle();
    endtask

    task automatic rnd_pipe_step(input logic creq, input logic cop, input logic [AW-1:0] sp,
                                 input logic [2*DW-1:0] cwd);
        step(1'b0, 1'b1, 1'b0, AW'($urandom), DW'($urandom), creq, cop, sp, cwd);
    endtask

    // Monitor: samples 2 time units after the driver, well away from the rising edge.
    initial begin
        cyc_t e;
        forever begin
            @(negedge Clk);
            #2;
            if (cq.size() > 0) begin
                e = cq.pop_front();
                chk("pipe_gnt", 32'(pipe_gnt), 32'(e.gnt));
                chk("pipe_stall", 32'(pipe_stall), 32'(e.stall));
                chk("mem_we", 32'(mem_we), 32'(e.we));
                chk("mem_re", 32'(mem_re), 32'(e.re));
                chk("mem_addr", 32'(mem_addr), 32'(e.addr));
                if (e.we || !e.re) chk("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
                if (e.chk_rd) chk("pipe_rdata", 32'(pipe_rdata), 32'(e.rdata));
                chk("ctx_done", 32'(ctx_done), 32'(e.done));
                chk("ctx_rdata", ctx_rdata, e.crd);
                chk("ctx_sp_out", 32'(ctx_sp_out), 32'(e.csp));
                mcyc++;
            end
        end
    end

    initial begin
        logic r;
        for (int i = 0; i < 2048; i++) ref_mem[i] = init_val(i);
        // Reset with a pending store, then the store proceeds once released.
        step(1'b1, 1'b1, 1'b1, 11'd5, 16'h1234, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b1, 1'b1, 11'd5, 16'h1234, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b1, 1'b1, 11'd5, 16'h1234, 1'b0, 1'b0, '0, '0);
        // Push/pop round trip with the pipeline requesting throughout.
        rnd_pipe_step(1'b1, 1'b0, 11'h100, 32'hABCD_5678);
        repeat (3) rnd_pipe_step(1'b0, 1'b0, '0, '0);
        rnd_pipe_step(1'b1, 1'b1, 11'h0FE, '0);
        repeat (3) rnd_pipe_step(1'b0, 1'b0, '0, '0);
        // Stack pointer wrap in both directions.
        rnd_pipe_step(1'b1, 1'b0, 11'd0, 32'h1357_2468);
        repeat (3) rnd_pipe_step(1'b0, 1'b0, '0, '0);
        rnd_pipe_step(1'b1, 1'b1, 11'd2046, '0);
        repeat (3) rnd_pipe_step(1'b0, 1'b0, '0, '0);
        // ctx_req held continuously: back-to-back bursts.
        for (int i = 0; i < 10; i++)
            rnd_pipe_step(1'b1, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
        repeat (4) rnd_pipe_step(1'b0, 1'b0, '0, '0);
        // Reset in XFER1 aborts the push; the later pop sees untouched memory.
        rnd_pipe_step(1'b1, 1'b0, 11'h300, 32'hDEAD_BEEF);
        step(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        repeat (2) rnd_pipe_step(1'b0, 1'b0, '0, '0);
        rnd_pipe_step(1'b1, 1'b1, 11'h2FE, '0);
        repeat (3) rnd_pipe_step(1'b0, 1'b0, '0, '0);
        // Random traffic with occasional resets (never in the completion cycle).
        for (int i = 0; i < 1500; i++) begin
            r = (k != 3) && ($urandom_range(0, 199) == 0);
            step(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom),
                 DW'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                 AW'($urandom), $urandom);
        end
        repeat (4) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge Clk);
        #3;
        chk("queue_drained", 32'(cq.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
